// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock with a registered
// inter-chunk carry, behind valid/ready handshakes on both sides.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic [IDXW-1:0]   idx_r;
    logic              accept_s;
    logic              last_s;
    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK:0]    chunk_s;
    logic              ovf_s;

    // Two's-complement overflow: operands share a sign that the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign in_ready  = (state_r == IDLE) && !reset;
    assign accept_s  = in_valid && in_ready;
    assign last_s    = (idx_r == LAST_IDX);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;

    // One chunk of the ripple add; on the last chunk its MSB is the result MSB.
    always_comb begin
        a_chunk_s = a_r[int'(idx_r) * CHUNK +: CHUNK];
        b_chunk_s = b_r[int'(idx_r) * CHUNK +: CHUNK];
        chunk_s   = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        ovf_s     = signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], chunk_s[CHUNK-1]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture and per-chunk accumulation; subtraction folds in as A + ~B + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= {IDXW{1'b0}};
                    end
                end
                BUSY: begin
                    sum_r[int'(idx_r) * CHUNK +: CHUNK] <= chunk_s[CHUNK-1:0];
                    carry_r <= chunk_s[CHUNK];
                    idx_r   <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        cout_r <= chunk_s[CHUNK];
                        ovf_r  <= ovf_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (8-bit/2-bit chunks) plus a 16-bit/4-bit
// instance exercised with random operations against an arithmetic model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [7:0]  a, b, sum;
    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_overflow;
    logic [15:0] w_a, w_b, w_sum;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .overflow(w_overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; hold>0 keeps out_ready low that many cycles in DONE.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                          input logic tsub, input logic [7:0] es, input logic ec,
                          input logic ev, input int hold, input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_val({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_val({tag, "_lat"}, cyc, 32'd4);
        check_val({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check_val({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ev});
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 2);
            a = 8'hAA; b = 8'h55; sub = 1'b0;
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_val({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, es});
            check_val({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    // One 16-bit operation checked against plain integer arithmetic.
    task automatic run_wide(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub);
        int ua, ub, full, sa, sb, sr, cyc;
        logic [15:0] es;
        logic ec, ev;
        ua = int'(ta); ub = int'(tb);
        sa = $signed(ta); sb = $signed(tb);
        full = tsub ? (ua - ub) : (ua + ub + int'(tcin));
        es = full[15:0];
        ec = tsub ? (ua >= ub) : (full > 65535);
        sr = tsub ? (sa - sb) : (sa + sb + int'(tcin));
        ev = (sr > 32767) || (sr < -32768);
        cyc = 0;
        while (!w_in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        w_a = ta; w_b = tb; w_cin = tcin; w_sub = tsub; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_a = ~ta; w_b = ~tb;
        cyc = 0;
        while (!w_out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_val("w_lat", cyc, 32'd4);
        check_val("w_sum", {16'd0, w_sum}, {16'd0, es});
        check_val("w_cout", {31'd0, w_cout}, {31'd0, ec});
        check_val("w_ovf", {31'd0, w_overflow}, {31'd0, ev});
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        cin = 1'b0; sub = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = 16'h0000; w_b = 16'h0000;
        w_cin = 1'b0; w_sub = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sum", {24'd0, sum}, 32'd0);
        check_val("rst_cout", {31'd0, cout}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow}, 32'd0);
        check_val("rst_ready_low", {31'd0, in_ready}, 32'd0);
        reset = 1'b0; #1;
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0, "add0f01");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, "addff01");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add7f01");
        run_op(8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 0, "addcin");
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "sub0507");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub8001");
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 5, "hold");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Abort during the second BUSY cycle.
        a = 8'hFF; b = 8'hFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("abort_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_sum", {24'd0, sum}, 32'd0);
        check_val("abort_cout", {31'd0, cout}, 32'd0);
        reset = 1'b0; #1;
        check_val("abort_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(8'hC3, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, "post_abort");

        run_wide(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_wide(16'h8000, 16'h0001, 1'b0, 1'b1);
        run_wide(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_wide(16'h0000, 16'h8000, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            run_wide(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
